// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access controller and the data memory.
// Request and attributes are level-held until a one-cycle ack pulse.
interface dmem_access_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: one request per load/store, stall of L+2 cycles (ack after L).
// Memory backpressure is absorbed by holding the request and stalling the pipeline; a watchdog aborts.
module dmem_access_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               MemRead_i,
   input  logic               MemWrite_i,
   input  logic [31:0]        addr_i,
   input  logic [31:0]        wdata_i,
   dmem_access_ctrl_if.master mem,
   output logic               stall_o,
   output logic [31:0]        rdata_o,
   output logic               err_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic             access;
   logic             timeout_hit;

   assign access      = MemRead_i | MemWrite_i;
   assign timeout_hit = (cnt == CNT_LAST);

   // DONE releases the stall so the completed instruction moves on to MEM/WB.
   always_comb begin
      stall_o = 1'b0;
      case (state)
         IDLE:    stall_o = access;
         BUSY:    stall_o = 1'b1;
         default: stall_o = 1'b0;
      endcase
   end

   assign mem.mem_req   = (state == BUSY);
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_o <= 32'd0;
         err_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (access) begin
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  we_q    <= MemWrite_i;
                  cnt     <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               // A late ack on the last watchdog cycle still counts as a normal completion.
               if (mem.mem_ack) begin
                  if (!we_q) begin
                     rdata_o <= mem.mem_rdata;
                  end
                  state <= DONE;
               end else if (timeout_hit) begin
                  err_o   <= 1'b1;
                  rdata_o <= 32'd0;
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequences data-memory accesses for the MEM stage of the pipelined CPU when the data memory has a variable-latency request/acknowledge interface. It watches the MemRead/MemWrite control bits carried in the EX/MEM latch and issues exactly one memory transaction per load or store. While that transaction is in flight it holds a stall that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB. A watchdog aborts transactions that are never acknowledged and sets a sticky error flag.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles mem_req_o may stay high without mem_ack_i before the access is aborted; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the watchdog counter.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- MemRead_i  in  1  EX/MEM latch: instruction in MEM is a load.
- MemWrite_i  in  1  EX/MEM latch: instruction in MEM is a store.
- addr_i  in  32  EX/MEM ALU result, byte address.
- wdata_i  in  32  EX/MEM store data.
- mem_req_o  out  1  request to data memory, level-held until ack.
- mem_we_o  out  1  1 = write, 0 = read; valid while mem_req_o = 1.
- mem_addr_o  out  32  registered address; valid while mem_req_o = 1.
- mem_wdata_o  out  32  registered store data; valid while mem_req_o = 1.
- mem_ack_i  in  1  memory completion, 1-cycle pulse; sampled only while mem_req_o = 1.
- mem_rdata_i  in  32  read data; valid in the cycle mem_ack_i = 1 for a read.
- stall_o  out  1  freeze all pipeline registers and PC.
- rdata_o  out  32  load result forwarded to MEM/WB.
- err_o  out  1  sticky watchdog-timeout flag.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: access = MemRead_i | MemWrite_i.
  - stall_o = access (combinational).
  - If access: latch addr_i, wdata_i and we = MemWrite_i into the output registers; clear the counter; go to BUSY.
  - If MemRead_i and MemWrite_i are both 1: a write is issued (write wins).
- BUSY: mem_req_o = 1, stall_o = 1; counter increments each cycle.
  - mem_ack_i = 1: for a read, rdata_o <= mem_rdata_i; for a write, rdata_o is unchanged. Go to DONE.
  - No ack and counter = TIMEOUT-1: err_o <= 1; rdata_o <= 0; go to DONE (abort).
  - Ack and timeout in the same cycle: the ack wins; err_o is not set.
- DONE: stall_o = 0 and mem_req_o = 0; the pipeline advances this cycle.
  - MemRead_i/MemWrite_i are ignored here: they still belong to the completed instruction.
  - Unconditionally return to IDLE.
- Non-memory instructions in IDLE: stall_o = 0; no request; no state change.
- err_o stays 1 until reset; the controller keeps operating normally after an error.
- rdata_o holds its value outside read completion and abort.
- Reset (rst_i = 0, at any time including mid-BUSY):
  - State = IDLE; mem_req_o = 0; mem_we_o = 0; mem_addr_o = 0; mem_wdata_o = 0; rdata_o = 0; err_o = 0; counter = 0.
  - stall_o follows the IDLE equation.
  - An in-flight ack arriving during or after reset is ignored.

## Timing
- Access seen in IDLE at cycle T: stall_o = 1 at T.
- mem_req_o rises at T+1.
- Ack at cycle T+1+L (L ≥ 0): DONE at T+2+L with rdata_o valid and stall_o = 0; IDLE at T+3+L.
- Stall length is L+2 cycles. Minimum (ack in first request cycle) is 2 stall cycles.
- Back-to-back memory instructions: the next access can be detected in IDLE at T+3+L, so there is one idle cycle between transactions.
- Timeout: mem_req_o is high for exactly TIMEOUT cycles, T+1..T+TIMEOUT; DONE at T+TIMEOUT+1 with err_o = 1.
- mem_addr_o, mem_wdata_o and mem_we_o are stable for the whole request.

## Test plan
- Load, L = 0: MemRead_i = 1, addr_i = 0x10; ack at T+1 with mem_rdata_i = 0xDEADBEEF -> stall_o high T..T+1, mem_we_o = 0, mem_addr_o = 0x10, rdata_o = 0xDEADBEEF at T+2, stall_o = 0 at T+2.
- Store, L = 3: MemWrite_i = 1, addr_i = 0x24, wdata_i = 0x12345678 -> mem_req_o high T+1..T+4, mem_we_o = 1, mem_wdata_o stable at 0x12345678, stall_o low at T+5, rdata_o unchanged.
- Back-to-back: lw, then sw in the next MEM slot -> exactly 2 requests, 1 idle cycle between them; DONE ignores the stale MemRead_i.
- Timeout with TIMEOUT = 4, no ack -> mem_req_o high for 4 cycles, DONE at T+5, err_o = 1 sticky, rdata_o = 0; a following load with ack completes normally with err_o still 1.
- Ack on the final watchdog cycle (T+TIMEOUT) -> normal completion, err_o stays 0.
- Reset mid-BUSY, with an ack one cycle later -> all outputs at reset values, IDLE, the late ack is ignored, and the next access is issued cleanly.
